// File: rtl/benes_route_ctrl_pkg.sv
// Shared FHE ALU constants and types for the Benes route controller.
// The controller and its beat counter both import this package.
package benes_route_ctrl_pkg;

  localparam int STAGE_NUM         = 9;
  localparam int SLOT_NUM          = 20;
  localparam int MODULE_NUM        = 20;
  localparam int BUFFER_READ_DELAY = 5;
  localparam int CNT_W             = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } route_state_e;

  // Slot-select word for one Benes stage: direction bit above the slot index.
  function automatic logic [15:0] slot_sel_word(input logic dir, input logic [7:0] slot);
    return {7'b0, dir, slot};
  endfunction

endpackage

// File: rtl/benes_route_ctrl_route_beat_counter.sv
// Loadable down-counter with terminal-count flag; one instance times every
// phase of the route controller (CFG, SETTLE, RUN, DRAIN).
module route_beat_counter #(
  parameter int W = benes_route_ctrl_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Counter holds "cycles remaining after this one", so zero marks the last cycle.
  assign tc = (count == '0);

endmodule

// File: rtl/benes_route_ctrl.sv
// Benes interconnect route controller: programs every stage with the
// module/slot selection, waits for the path to settle, streams the beats,
// then drains the pipeline before reporting done.
//
// Request handshake: a request transfers on a rising edge where
// req_valid && req_ready; req_ready is high only while idle, and all req_*
// fields are captured on that edge. req_valid may stay high while busy; it
// is simply not sampled until the controller is idle again.
module benes_route_ctrl #(
  parameter int STAGE_NUM  = benes_route_ctrl_pkg::STAGE_NUM,
  parameter int SLOT_NUM   = benes_route_ctrl_pkg::SLOT_NUM,
  parameter int MODULE_NUM = benes_route_ctrl_pkg::MODULE_NUM,
  parameter int SETTLE_CYC = benes_route_ctrl_pkg::BUFFER_READ_DELAY
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dir,
  input  logic [7:0]  req_module,
  input  logic [7:0]  req_slot,
  input  logic [31:0] req_base,
  input  logic [15:0] req_len,
  output logic        cfg_we,
  output logic [3:0]  cfg_stage,
  output logic [15:0] cfg_module_sel,
  output logic [15:0] cfg_slot_sel,
  output logic        xfer_en,
  output logic        xfer_wren,
  output logic [31:0] xfer_addr,
  output logic [7:0]  xfer_slot,
  output logic [7:0]  xfer_module,
  output logic        done,
  output logic        err,
  output logic        busy
);
  import benes_route_ctrl_pkg::*;

  localparam logic [15:0] CFG_LAST    = 16'(STAGE_NUM - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(STAGE_NUM - 1);
  localparam logic [7:0]  MOD_LIM     = 8'(MODULE_NUM);
  localparam logic [7:0]  SLOT_LIM    = 8'(SLOT_NUM);
  localparam logic        DONE_ON_ENTRY = (STAGE_NUM == 1);

  route_state_e state;

  logic [7:0]  module_q;
  logic [7:0]  slot_q;
  logic        dir_q;
  logic [31:0] base_q;
  logic [15:0] len_q;

  logic        accept;
  logic        req_ok;
  logic        cnt_load;
  logic        cnt_en;
  logic [15:0] cnt_val;
  logic [15:0] cnt;
  logic        cnt_tc;

  assign accept = req_valid && req_ready;
  assign req_ok = (req_module < MOD_LIM) && (req_slot < SLOT_LIM);

  // Each phase reloads the counter on its final cycle with the next phase's length.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (accept && req_ok) begin
          cnt_load = 1'b1;
          cnt_val  = CFG_LAST;
        end
      end
      ST_CFG: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LAST;
        end
      end
      ST_SETTLE: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          cnt_val  = (len_q != 16'd0) ? (len_q - 16'd1) : DRAIN_LAST;
        end
      end
      ST_RUN: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          cnt_val  = DRAIN_LAST;
        end
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  route_beat_counter #(.W(16)) u_beat_counter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  // Outputs are assigned from the next-state decision so they line up with
  // the state register and never see req_* combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      module_q       <= '0;
      slot_q         <= '0;
      dir_q          <= 1'b0;
      base_q         <= '0;
      len_q          <= '0;
      req_ready      <= 1'b1;
      cfg_we         <= 1'b0;
      cfg_stage      <= '0;
      cfg_module_sel <= '0;
      cfg_slot_sel   <= '0;
      xfer_en        <= 1'b0;
      xfer_wren      <= 1'b0;
      xfer_addr      <= '0;
      xfer_slot      <= '0;
      xfer_module    <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      busy           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            module_q <= req_module;
            slot_q   <= req_slot;
            dir_q    <= req_dir;
            base_q   <= req_base;
            len_q    <= req_len;
            if (!req_ok) begin
              err <= 1'b1;
            end else begin
              state          <= ST_CFG;
              req_ready      <= 1'b0;
              busy           <= 1'b1;
              cfg_we         <= 1'b1;
              cfg_stage      <= '0;
              cfg_module_sel <= {8'h00, req_module};
              cfg_slot_sel   <= slot_sel_word(req_dir, req_slot);
            end
          end
        end
        ST_CFG: begin
          if (cnt_tc) begin
            state          <= ST_SETTLE;
            cfg_we         <= 1'b0;
            cfg_stage      <= '0;
            cfg_module_sel <= '0;
            cfg_slot_sel   <= '0;
          end else begin
            cfg_stage <= cfg_stage + 4'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt_tc) begin
            if (len_q != 16'd0) begin
              state       <= ST_RUN;
              xfer_en     <= 1'b1;
              xfer_wren   <= dir_q;
              xfer_addr   <= base_q;
              xfer_slot   <= slot_q;
              xfer_module <= module_q;
            end else begin
              state <= ST_DRAIN;
              done  <= DONE_ON_ENTRY;
            end
          end
        end
        ST_RUN: begin
          if (cnt_tc) begin
            state       <= ST_DRAIN;
            done        <= DONE_ON_ENTRY;
            xfer_en     <= 1'b0;
            xfer_wren   <= 1'b0;
            xfer_addr   <= '0;
            xfer_slot   <= '0;
            xfer_module <= '0;
          end else begin
            xfer_addr <= xfer_addr + 32'd1;
          end
        end
        ST_DRAIN: begin
          if (cnt_tc) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else if (cnt == 16'd1) begin
            // Raise done one edge early so it coincides with the last drain cycle.
            done <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_benes_route_ctrl.sv
// Directed bench for benes_route_ctrl: a timeline model checks every output
// every cycle, and literal expectations pin latency, addresses and selects.
module tb_benes_route_ctrl;

  localparam int S = 9;
  localparam int D = 5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_dir = 1'b0;
  logic [7:0]  req_module = '0;
  logic [7:0]  req_slot = '0;
  logic [31:0] req_base = '0;
  logic [15:0] req_len = '0;
  logic        cfg_we;
  logic [3:0]  cfg_stage;
  logic [15:0] cfg_module_sel;
  logic [15:0] cfg_slot_sel;
  logic        xfer_en;
  logic        xfer_wren;
  logic [31:0] xfer_addr;
  logic [7:0]  xfer_slot;
  logic [7:0]  xfer_module;
  logic        done;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  benes_route_ctrl dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_module(req_module), .req_slot(req_slot), .req_base(req_base), .req_len(req_len),
    .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_module_sel(cfg_module_sel),
    .cfg_slot_sel(cfg_slot_sel),
    .xfer_en(xfer_en), .xfer_wren(xfer_wren), .xfer_addr(xfer_addr),
    .xfer_slot(xfer_slot), .xfer_module(xfer_module),
    .done(done), .err(err), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  // Model state: cycle index since accept of the active request.
  bit          cmp_on = 0;
  bit          m_active = 0;
  bit          m_err = 0;
  int          m_k = 0;
  int          m_total = 0;
  int          m_len = 0;
  logic        m_dir = 1'b0;
  logic [7:0]  m_mod = '0;
  logic [7:0]  m_slot = '0;
  logic [31:0] m_base = '0;

  int          beats = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] last_ssel = '0;
  logic        last_wren = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rstn) begin
      m_active = 0;
      m_err = 0;
      m_k = 0;
      cmp_on = 1;
    end else if (m_active) begin
      m_err = 0;
      m_k++;
      if (m_k > m_total) begin
        m_active = 0;
        m_k = 0;
      end
    end else begin
      m_err = 0;
      if (req_valid) begin
        if (req_module >= 8'd20 || req_slot >= 8'd20) begin
          m_err = 1;
        end else begin
          m_active = 1;
          m_k = 1;
          m_dir = req_dir;
          m_mod = req_module;
          m_slot = req_slot;
          m_base = req_base;
          m_len = int'(req_len);
          m_total = S + D + m_len + S;
        end
      end
    end
  end

  function automatic logic [90:0] expected_vec();
    logic        rdy = 1'b0, we = 1'b0, xen = 1'b0, wr = 1'b0, dn = 1'b0, er = 1'b0, bz = 1'b0;
    logic [3:0]  stg = '0;
    logic [15:0] msel = '0, ssel = '0;
    logic [31:0] addr = '0;
    logic [7:0]  xs = '0, xm = '0;
    if (!m_active) begin
      rdy = 1'b1;
      er = m_err;
    end else begin
      bz = 1'b1;
      if (m_k <= S) begin
        we = 1'b1;
        stg = 4'(m_k - 1);
        msel = {8'h00, m_mod};
        ssel = (m_dir ? 16'h0100 : 16'h0000) + {8'h00, m_slot};
      end else if (m_k > S + D && m_k <= S + D + m_len) begin
        xen = 1'b1;
        wr = m_dir;
        addr = m_base + 32'(m_k - S - D - 1);
        xs = m_slot;
        xm = m_mod;
      end else if (m_k > S + D + m_len) begin
        dn = (m_k == m_total);
      end
    end
    return {rdy, we, stg, msel, ssel, xen, wr, addr, xs, xm, dn, er, bz};
  endfunction

  always @(negedge clk) begin
    logic [90:0] e_vec, a_vec;
    if (cmp_on) begin
      e_vec = expected_vec();
      a_vec = {req_ready, cfg_we, cfg_stage, cfg_module_sel, cfg_slot_sel, xfer_en, xfer_wren,
               xfer_addr, xfer_slot, xfer_module, done, err, busy};
      total++;
      if (a_vec !== e_vec) begin
        bad++;
        $display("FAIL cycle t=%0t got %h want %h", $time, a_vec, e_vec);
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (cfg_we) last_ssel = cfg_slot_sel;
      if (xfer_en) begin
        beats++;
        last_wren = xfer_wren;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat unexpected: got addr 0x%08h want no beat", xfer_addr);
        end else begin
          check("beat addr", xfer_addr, exp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic dir, input logic [7:0] mod, input logic [7:0] slot,
                       input logic [31:0] base, input logic [15:0] len);
    bit ok = 0;
    @(posedge clk); #2;
    req_valid = 1'b1;
    req_dir = dir;
    req_module = mod;
    req_slot = slot;
    req_base = base;
    req_len = len;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept timeout: got no req_ready want req_ready");
    end
  endtask

  task automatic wait_done(output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) n = -1;
  endtask

  initial begin
    int n;
    bit busy_seen;
    bit found;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {26'd0, req_ready, busy, done, err, cfg_we, xfer_en}, 32'h20);
    @(posedge clk); #2;
    rstn = 1'b1;

    // Read transfer
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i));
    beats = 0;
    issue(1'b0, 8'd3, 8'd7, 32'h100, 16'd4);
    wait_done(n);
    check("read done cycle", n, 27);
    check("read cfg_slot_sel", {16'h0, last_ssel}, 32'h0007);
    check("read wren", {31'h0, last_wren}, 32'h0);
    check("read beats", beats, 4);
    check("read queue empty", exp_q.size(), 0);

    // Write transfer, top slot
    exp_q.push_back(32'h40);
    beats = 0;
    issue(1'b1, 8'd5, 8'd19, 32'h40, 16'd1);
    wait_done(n);
    check("write done cycle", n, 24);
    check("write cfg_slot_sel", {16'h0, last_ssel}, 32'h0113);
    check("write wren", {31'h0, last_wren}, 32'h1);
    check("write beats", beats, 1);

    // Out-of-range module then slot
    for (int t = 0; t < 2; t++) begin
      err_cnt = 0;
      busy_seen = 0;
      if (t == 0) issue(1'b0, 8'd20, 8'd3, 32'h0, 16'd2);
      else        issue(1'b0, 8'd3, 8'd20, 32'h0, 16'd2);
      @(negedge clk);
      check("reject err cycle1", {31'h0, err}, 32'h1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (busy || cfg_we) busy_seen = 1;
      end
      check("reject err count", err_cnt, 1);
      check("reject stays idle", {31'h0, busy_seen}, 32'h0);
    end
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h11);
    issue(1'b0, 8'd19, 8'd19, 32'h10, 16'd2);
    wait_done(n);
    check("after reject done cycle", n, 25);

    // Zero length
    beats = 0;
    issue(1'b0, 8'd1, 8'd1, 32'h0, 16'd0);
    wait_done(n);
    check("len0 done cycle", n, 23);
    check("len0 beats", beats, 0);

    // Address wrap
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    issue(1'b0, 8'd2, 8'd4, 32'hFFFF_FFFE, 16'd3);
    wait_done(n);
    check("wrap done cycle", n, 26);
    check("wrap queue empty", exp_q.size(), 0);

    // Reset during RUN beat 2
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h201);
    issue(1'b1, 8'd6, 8'd8, 32'h200, 16'd8);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (xfer_en && xfer_addr == 32'h201) begin
        found = 1;
        break;
      end
    end
    check("reset beat2 reached", {31'h0, found}, 32'h1);
    rstn = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    check("midrun reset outputs", {26'd0, req_ready, busy, done, err, cfg_we, xfer_en}, 32'h20);
    @(posedge clk); #2;
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("no done after abort", done_cnt, 0);
    check("abort queue empty", exp_q.size(), 0);

    // Back-to-back with valid held during busy
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h301);
    exp_q.push_back(32'h400);
    @(posedge clk); #2;
    req_valid = 1'b1;
    req_dir = 1'b0; req_module = 8'd1; req_slot = 8'd2; req_base = 32'h300; req_len = 16'd2;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        found = 1;
        break;
      end
    end
    check("b2b first accept", {31'h0, found}, 32'h1);
    @(posedge clk); #2;
    req_dir = 1'b1; req_module = 8'd4; req_slot = 8'd5; req_base = 32'h400; req_len = 16'd1;
    wait_done(n);
    check("b2b first done cycle", n, 25);
    @(negedge clk);
    check("b2b ready after done", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_done(n);
    check("b2b second done cycle", n, 24);
    check("b2b queue empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/benes_route_ctrl.md
BENES_ROUTE_CTRL -- requirements
Module: benes_route_ctrl

Interface
REQ-001 Parameters SHALL be: STAGE_NUM (default 9), Benes stage count; SLOT_NUM (default 20), buffer RAM slots; MODULE_NUM (default 20), arithmetic modules; SETTLE_CYC (default 5), path settle cycles (BUFFER_READ_DELAY).
REQ-002 Clock and reset SHALL be: clk  in  1  single clock; rstn  in  1  reset, synchronous, active-low.
REQ-003 Request port SHALL be: req_valid in 1; req_ready out 1; req_dir in 1 (0 = slot-to-module read, 1 = module-to-slot write); req_module in 8; req_slot in 8; req_base in 32; req_len in 16 (beats).
REQ-004 Configuration port SHALL be: cfg_we out 1; cfg_stage out 4; cfg_module_sel out 16; cfg_slot_sel out 16. These drive the per-stage module-select and slot-select words of the Benes interconnect.
REQ-005 Transfer port SHALL be: xfer_en out 1; xfer_wren out 1; xfer_addr out 32; xfer_slot out 8; xfer_module out 8.
REQ-006 Status port SHALL be: done out 1 (one-cycle pulse); err out 1 (one-cycle pulse); busy out 1.

Function
REQ-007 FSM states SHALL be IDLE, CFG, SETTLE, RUN, DRAIN.
REQ-008 req_ready SHALL be 1 only in IDLE. A request is accepted when req_valid && req_ready; all request fields are latched on that edge.
REQ-009 An accepted request with req_module >= MODULE_NUM or req_slot >= SLOT_NUM SHALL be rejected:
  - err pulses the next cycle;
  - the FSM stays in IDLE;
  - no cfg_we or xfer_en is asserted.
REQ-010 CFG SHALL last exactly STAGE_NUM cycles. On each cycle:
  - cfg_we = 1 and cfg_stage = 0..STAGE_NUM-1 in ascending order;
  - cfg_module_sel = zero-extended latched module;
  - cfg_slot_sel = {7'b0, dir, slot[7:0]}.
REQ-011 SETTLE SHALL last exactly SETTLE_CYC cycles with no cfg_we and no xfer_en.
REQ-012 RUN SHALL last exactly req_len cycles. On each cycle:
  - xfer_en = 1;
  - xfer_wren = dir;
  - xfer_addr = base + beat, beat counting 0..len-1, 32-bit wrap-around modulo 2^32;
  - xfer_slot and xfer_module hold the latched values.
REQ-013 DRAIN SHALL last STAGE_NUM cycles. done pulses on the last DRAIN cycle and the FSM then returns to IDLE.
REQ-014 req_len = 0 SHALL skip RUN; SETTLE goes directly to DRAIN.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Latency from accept to done SHALL be STAGE_NUM + SETTLE_CYC + len + STAGE_NUM cycles. With defaults this is 23 + len.
REQ-017 req_valid held high during busy SHALL be ignored and not lost; it is accepted on the first IDLE cycle.
REQ-018 Outputs not named active in the current state SHALL be 0.

Reset
REQ-019 When rstn = 0 at a clock edge:
  - the FSM goes to IDLE and all counters clear;
  - every output is 0 except req_ready, which is 1.
REQ-020 Reset asserted mid-operation (any state) SHALL abort the transfer with no done and no err; the aborted request is not resumed.

Structure
REQ-021 Constants STAGE_NUM, SLOT_NUM, MODULE_NUM, BUFFER_READ_DELAY and the state enum type SHALL reside in the shared FHE ALU package.
REQ-022 A single sub-module, route_beat_counter, SHALL implement the loadable down-counter with terminal-count flag reused for CFG, SETTLE, RUN and DRAIN.
REQ-023 The implementation SHALL be one FSM with registered outputs and no combinational path from req_* to cfg_* or xfer_*.

Verification
REQ-024 Read transfer: module=3, slot=7, dir=0, base=0x100, len=4.
  - cfg_we for stages 0..8, each with cfg_slot_sel=0x0007;
  - 5 idle cycles;
  - xfer_addr 0x100..0x103 with xfer_wren=0;
  - done at cycle 27 after accept.
REQ-025 Write transfer: slot=19, dir=1, len=1.
  - cfg_slot_sel=0x0113;
  - one beat with xfer_wren=1;
  - done at cycle 24.
REQ-026 Out-of-range request: module=20 or slot=20.
  - err pulses once;
  - busy stays 0;
  - no cfg_we;
  - a following valid request completes normally.
REQ-027 Zero length and address wrap:
  - len=0: no xfer_en, done at cycle 23;
  - base=0xFFFFFFFE, len=3: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-028 Reset and back-to-back:
  - rstn low during RUN beat 2: next cycle all outputs 0, req_ready 1, no done;
  - second request held valid during busy: accepted on the cycle after done.
